// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the multiplexed 7-segment display path.
//   - Segment patterns, active-high, bit order {g,f,e,d,c,b,a}.
//   - Default scan-timing values used by seg_scan_driver.
// -----------------------------------------------------------------------------
package seg_pkg;

    // Segment patterns, active-high, {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    // Scan-timing defaults
    localparam int DEF_NUM_DIGITS   = 4;
    localparam int DEF_SCAN_DIV     = 1024;
    localparam int DEF_BLANK_CYCLES = 16;

    // True when a nibble is a valid decimal digit (0..9)
    function automatic logic is_bcd_digit(input logic [3:0] nibble);
        return (nibble <= 4'd9);
    endfunction

endpackage

// File: rtl/bcd_seg_decode.sv
// -----------------------------------------------------------------------------
// bcd_seg_decode
// Combinational nibble-to-segment decoder, active-high output.
//   nibble : 4-bit BCD value; 10..15 render as a dash (g only)
//   blank  : 1 forces all segments off regardless of nibble
//   seg    : {g,f,e,d,c,b,a}, 1 = segment lit
// -----------------------------------------------------------------------------
module bcd_seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg
);

    // Decode the nibble; blanking wins over any digit value
    always_comb begin
        seg = SEG_OFF;
        if (blank) begin
            seg = SEG_OFF;
        end else if (!is_bcd_digit(nibble)) begin
            seg = SEG_DASH;
        end else begin
            case (nibble)
                4'd0:    seg = SEG_0;
                4'd1:    seg = SEG_1;
                4'd2:    seg = SEG_2;
                4'd3:    seg = SEG_3;
                4'd4:    seg = SEG_4;
                4'd5:    seg = SEG_5;
                4'd6:    seg = SEG_6;
                4'd7:    seg = SEG_7;
                4'd8:    seg = SEG_8;
                4'd9:    seg = SEG_9;
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
// Time-multiplexed 7-segment driver. NUM_DIGITS displays share one 7-bit
// segment bus; one digit is enabled per scan slot of SCAN_DIV clocks. The first
// BLANK_CYCLES of every slot keep all digits off so the previous digit's
// segments never ghost onto the next one. The BCD value is snapshotted once
// per frame so a changing input never produces a torn display.
//
// Ports:
//   clk         : system clock
//   reset       : asynchronous, active-high reset
//   bcd_in      : packed BCD, nibble i = digit i (digit 0 least significant)
//   lzb_en      : leading-zero blanking enable, sampled with the snapshot
//   seg         : {g,f,e,d,c,b,a}, inverted when SEG_ACTIVE_LOW
//   dig         : one-hot digit enable, inverted when DIG_ACTIVE_LOW
//   frame_start : one-cycle pulse in the first cycle of a new frame
// -----------------------------------------------------------------------------
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS     = DEF_NUM_DIGITS,
    parameter int SCAN_DIV       = DEF_SCAN_DIV,
    parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    lzb_en,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig,
    output logic                    frame_start
);

    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] BLANK_LIM = PRE_W'(BLANK_CYCLES);

    // XOR masks: inactive level of each output bus is exactly its mask
    localparam logic [6:0]            SEG_MASK = {7{SEG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_MASK = {NUM_DIGITS{DIG_ACTIVE_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_ONE  = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

    logic [PRE_W-1:0]        pre_r;
    logic [IDX_W-1:0]        idx_r;
    logic [4*NUM_DIGITS-1:0] snap_r;
    logic                    snap_lzb_r;
    logic                    frame_start_r;
    logic [6:0]              seg_r;
    logic [NUM_DIGITS-1:0]   dig_r;

    logic                    slot_end_s;
    logic                    frame_end_s;
    logic                    live_s;
    logic [NUM_DIGITS-1:0]   lead_blank_s;
    logic [3:0]              nibble_s;
    logic                    digit_blank_s;
    logic [6:0]              dec_seg_s;
    logic [6:0]              seg_s;
    logic [NUM_DIGITS-1:0]   dig_s;

    assign slot_end_s  = (pre_r == PRE_MAX);
    assign frame_end_s = slot_end_s && (idx_r == IDX_MAX);
    // Dead time occupies the first BLANK_CYCLES prescaler values of a slot
    assign live_s      = (pre_r >= BLANK_LIM);

    // Prescaler and digit index: idx advances once per slot and wraps per frame
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_r <= '0;
            idx_r <= '0;
        end else if (slot_end_s) begin
            pre_r <= '0;
            if (idx_r == IDX_MAX) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + 1'b1;
            end
        end else begin
            pre_r <= pre_r + 1'b1;
        end
    end

    // Frame snapshot of value and blanking mode, plus the frame_start pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            snap_r        <= '0;
            snap_lzb_r    <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            frame_start_r <= frame_end_s;
            if (frame_end_s) begin
                snap_r     <= bcd_in;
                snap_lzb_r <= lzb_en;
            end else begin
                snap_r     <= snap_r;
                snap_lzb_r <= snap_lzb_r;
            end
        end
    end

    // Leading-zero mask: walk from the top digit down while nibbles stay zero.
    // The first nonzero nibble ends the run, so inner zeros stay visible.
    always_comb begin
        logic zero_run;
        zero_run     = 1'b1;
        lead_blank_s = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_run        = zero_run & (snap_r[4*i +: 4] == 4'd0);
            lead_blank_s[i] = snap_lzb_r & zero_run;
        end
        lead_blank_s[0] = 1'b0;
    end

    assign nibble_s      = snap_r[{idx_r, 2'b00} +: 4];
    assign digit_blank_s = lead_blank_s[idx_r];

    bcd_seg_decode u_decode (
        .nibble (nibble_s),
        .blank  (digit_blank_s),
        .seg    (dec_seg_s)
    );

    // Active-high segment/enable values for the current slot position
    always_comb begin
        seg_s = SEG_OFF;
        dig_s = '0;
        if (live_s && !digit_blank_s) begin
            seg_s = dec_seg_s;
            dig_s = DIG_ONE << idx_r;
        end else begin
            seg_s = SEG_OFF;
            dig_s = '0;
        end
    end

    // Output register; polarity is applied only here
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg_r <= SEG_MASK;
            dig_r <= DIG_MASK;
        end else begin
            seg_r <= seg_s ^ SEG_MASK;
            dig_r <= dig_s ^ DIG_MASK;
        end
    end

    assign seg         = seg_r;
    assign dig         = dig_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
// Directed bench for seg_scan_driver with NUM_DIGITS=4, SCAN_DIV=8,
// BLANK_CYCLES=2, both outputs active-low. Outputs are sampled on the falling
// clock edge. A frame is captured as 32 consecutive samples; sample j shows
// slot j/8 at prescaler position j%8 (one-cycle output latency).
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int ND = 4;
    localparam int SDIV = 8;
    localparam int BC = 2;
    localparam int FL = ND * SDIV;

    // Hand-written active-high segment patterns {g,f,e,d,c,b,a}
    localparam logic [6:0] P0 = 7'b0111111;
    localparam logic [6:0] P1 = 7'b0000110;
    localparam logic [6:0] P2 = 7'b1011011;
    localparam logic [6:0] P3 = 7'b1001111;
    localparam logic [6:0] P4 = 7'b1100110;
    localparam logic [6:0] P5 = 7'b1101101;
    localparam logic [6:0] P6 = 7'b1111101;
    localparam logic [6:0] P7 = 7'b0000111;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1101111;
    localparam logic [6:0] PDASH = 7'b1000000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [15:0]   bcd_in = 16'h0000;
    logic          lzb_en = 1'b0;
    logic [6:0]    seg;
    logic [ND-1:0] dig;
    logic          frame_start;

    int total = 0;
    int bad = 0;

    logic [6:0]    obs_seg [FL];
    logic [ND-1:0] obs_dig [FL];
    logic          obs_fs  [FL];
    logic [6:0]    exp_seg [FL];
    logic [ND-1:0] exp_dig [FL];

    seg_scan_driver #(
        .NUM_DIGITS     (ND),
        .SCAN_DIV       (SDIV),
        .BLANK_CYCLES   (BC),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bcd_in      (bcd_in),
        .lzb_en      (lzb_en),
        .seg         (seg),
        .dig         (dig),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Expected active-low frame from per-digit patterns and a lit mask
    task automatic build_expected(input logic [6:0] s3, input logic [6:0] s2,
                                  input logic [6:0] s1, input logic [6:0] s0,
                                  input logic [3:0] lit);
        logic [6:0] ds [4];
        ds[0] = s0; ds[1] = s1; ds[2] = s2; ds[3] = s3;
        for (int j = 0; j < FL; j++) begin
            int p;
            int d;
            p = j % SDIV;
            d = j / SDIV;
            if (p < BC || !lit[d]) begin
                exp_seg[j] = 7'b1111111;
                exp_dig[j] = 4'b1111;
            end else begin
                exp_seg[j] = ~ds[d];
                exp_dig[j] = ~(4'b0001 << d);
            end
        end
    endtask

    task automatic capture_frame();
        for (int j = 0; j < FL; j++) begin
            @(negedge clk);
            obs_seg[j] = seg;
            obs_dig[j] = dig;
            obs_fs[j]  = frame_start;
        end
    endtask

    task automatic wait_frame();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (frame_start) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL wait_frame: frame_start=0 after 200 cycles, required 1");
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        bcd_in = 16'h1234;
        lzb_en = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (seg !== 7'b1111111) begin
            bad++;
            $display("FAIL reset_seg: got %b required 1111111", seg);
        end
        total++;
        if (dig !== 4'b1111) begin
            bad++;
            $display("FAIL reset_dig: got %b required 1111", dig);
        end
        total++;
        if (frame_start !== 1'b0) begin
            bad++;
            $display("FAIL reset_fs: got %b required 0", frame_start);
        end
        reset = 1'b0;
        capture_frame();
        build_expected(P0, P0, P0, P0, 4'b1111);
        for (int j = 0; j < FL; j++) begin
            total++;
            if (obs_seg[j] !== exp_seg[j] || obs_dig[j] !== exp_dig[j]) begin
                bad++;
                $display("FAIL first_frame j=%0d: got seg=%b dig=%b required seg=%b dig=%b",
                         j, obs_seg[j], obs_dig[j], exp_seg[j], exp_dig[j]);
            end
            total++;
            if (obs_fs[j] !== (j == FL - 1)) begin
                bad++;
                $display("FAIL first_frame_fs j=%0d: got %b required %b",
                         j, obs_fs[j], (j == FL - 1));
            end
        end
    endtask

    // Continues straight from test_reset: the next samples are frame 2
    task automatic test_scan_1234();
        int cnt;
        capture_frame();
        build_expected(P1, P2, P3, P4, 4'b1111);
        for (int j = 0; j < FL; j++) begin
            total++;
            if (obs_seg[j] !== exp_seg[j] || obs_dig[j] !== exp_dig[j]) begin
                bad++;
                $display("FAIL scan_1234 j=%0d: got seg=%b dig=%b required seg=%b dig=%b",
                         j, obs_seg[j], obs_dig[j], exp_seg[j], exp_dig[j]);
            end
        end
        for (int d = 0; d < ND; d++) begin
            cnt = 0;
            for (int j = d * SDIV; j < (d + 1) * SDIV; j++) begin
                if (obs_dig[j][d] == 1'b0) cnt++;
            end
            total++;
            if (cnt != 6) begin
                bad++;
                $display("FAIL enable_width d=%0d: got %0d cycles required 6", d, cnt);
            end
        end
    endtask

    task automatic test_lzb();
        logic [15:0] vals [3];
        logic [6:0]  s3 [3];
        logic [6:0]  s2 [3];
        logic [6:0]  s1 [3];
        logic [6:0]  s0 [3];
        logic [3:0]  lit [3];
        vals[0] = 16'h0007; s3[0] = P0; s2[0] = P0; s1[0] = P0; s0[0] = P7; lit[0] = 4'b0001;
        vals[1] = 16'h0000; s3[1] = P0; s2[1] = P0; s1[1] = P0; s0[1] = P0; lit[1] = 4'b0001;
        vals[2] = 16'h0105; s3[2] = P0; s2[2] = P1; s1[2] = P0; s0[2] = P5; lit[2] = 4'b0111;
        lzb_en = 1'b1;
        for (int v = 0; v < 3; v++) begin
            bcd_in = vals[v];
            wait_frame();
            capture_frame();
            build_expected(s3[v], s2[v], s1[v], s0[v], lit[v]);
            for (int j = 0; j < FL; j++) begin
                total++;
                if (obs_seg[j] !== exp_seg[j] || obs_dig[j] !== exp_dig[j]) begin
                    bad++;
                    $display("FAIL lzb_%h j=%0d: got seg=%b dig=%b required seg=%b dig=%b",
                             vals[v], j, obs_seg[j], obs_dig[j], exp_seg[j], exp_dig[j]);
                end
            end
        end
        lzb_en = 1'b0;
    endtask

    task automatic test_invalid();
        bcd_in = 16'h00A9;
        lzb_en = 1'b0;
        wait_frame();
        capture_frame();
        build_expected(P0, P0, PDASH, P9, 4'b1111);
        for (int j = 0; j < FL; j++) begin
            total++;
            if (obs_seg[j] !== exp_seg[j] || obs_dig[j] !== exp_dig[j]) begin
                bad++;
                $display("FAIL invalid_bcd j=%0d: got seg=%b dig=%b required seg=%b dig=%b",
                         j, obs_seg[j], obs_dig[j], exp_seg[j], exp_dig[j]);
            end
        end
    endtask

    task automatic test_snapshot();
        bcd_in = 16'h1111;
        lzb_en = 1'b0;
        wait_frame();
        for (int j = 0; j < FL; j++) begin
            @(negedge clk);
            obs_seg[j] = seg;
            obs_dig[j] = dig;
            if (j == 12) bcd_in = 16'h2222;
        end
        build_expected(P1, P1, P1, P1, 4'b1111);
        for (int j = 0; j < FL; j++) begin
            total++;
            if (obs_seg[j] !== exp_seg[j] || obs_dig[j] !== exp_dig[j]) begin
                bad++;
                $display("FAIL snapshot_old j=%0d: got seg=%b dig=%b required seg=%b dig=%b",
                         j, obs_seg[j], obs_dig[j], exp_seg[j], exp_dig[j]);
            end
        end
        capture_frame();
        build_expected(P2, P2, P2, P2, 4'b1111);
        for (int j = 0; j < FL; j++) begin
            total++;
            if (obs_seg[j] !== exp_seg[j] || obs_dig[j] !== exp_dig[j]) begin
                bad++;
                $display("FAIL snapshot_new j=%0d: got seg=%b dig=%b required seg=%b dig=%b",
                         j, obs_seg[j], obs_dig[j], exp_seg[j], exp_dig[j]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bcd_in = 16'h9876;
        lzb_en = 1'b0;
        repeat (13) @(negedge clk);
        // Land in the middle of a lit cycle of slot 1
        total++;
        if (dig === 4'b1111) begin
            bad++;
            $display("FAIL pre_reset_lit: got dig=%b required a lit digit", dig);
        end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (seg !== 7'b1111111 || dig !== 4'b1111) begin
            bad++;
            $display("FAIL mid_reset_async: got seg=%b dig=%b required seg=1111111 dig=1111",
                     seg, dig);
        end
        total++;
        if (frame_start !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_fs: got %b required 0", frame_start);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        capture_frame();
        build_expected(P0, P0, P0, P0, 4'b1111);
        for (int j = 0; j < FL; j++) begin
            total++;
            if (obs_seg[j] !== exp_seg[j] || obs_dig[j] !== exp_dig[j] ||
                obs_fs[j] !== (j == FL - 1)) begin
                bad++;
                $display("FAIL after_reset j=%0d: got seg=%b dig=%b fs=%b required seg=%b dig=%b fs=%b",
                         j, obs_seg[j], obs_dig[j], obs_fs[j], exp_seg[j], exp_dig[j], (j == FL - 1));
            end
        end
        capture_frame();
        build_expected(P9, P8, P7, P6, 4'b1111);
        for (int j = 0; j < FL; j++) begin
            total++;
            if (obs_seg[j] !== exp_seg[j] || obs_dig[j] !== exp_dig[j]) begin
                bad++;
                $display("FAIL after_reset_9876 j=%0d: got seg=%b dig=%b required seg=%b dig=%b",
                         j, obs_seg[j], obs_dig[j], exp_seg[j], exp_dig[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan_1234();
        test_lzb();
        test_invalid();
        test_snapshot();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
